// File: rtl/fab_clk_pkg.sv
// Shared types and constants for the fabric clock/reset sequencer.
// Holds the sequencer state encoding, output widths and divider sizing helpers.
package fab_clk_pkg;

    localparam int EPOCH_W = 16;
    localparam int LOSS_W  = 8;

    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_WAIT_LOCK  = 2'd1,
        ST_STRETCH    = 2'd2,
        ST_RUN        = 2'd3
    } seq_state_e;

    // Integer ratio num/den, or 0 when the division is not exact.
    function automatic int div_ratio(input int num, input int den);
        if (den <= 0) return 0;
        if (num % den != 0) return 0;
        return num / den;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fab_clk_sequencer_tick_divider.sv
// Event divider: emits a registered one-cycle pulse on every DIV-th enabled event.
// fire_o is the unregistered form of that pulse so a second divider can be cascaded in phase.
module tick_divider
    import fab_clk_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk_i,
    input  logic en_i,
    input  logic clr_i,
    output logic fire_o,
    output logic pulse_o
);

    localparam int CW = cnt_width(DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pulse_q;
    logic          at_term;

    assign at_term = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d  = cnt_q;
        fire_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            fire_o = at_term;
            cnt_d  = at_term ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q   <= cnt_d;
        pulse_q <= fire_o;
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/fab_clk_sequencer.sv
// Fabric reset sequencer: waits for a trusted clock, stretches reset, then runs
// fast/slow control-loop ticks and an epoch counter.
module fab_clk_sequencer
    import fab_clk_pkg::*;
#(
    parameter int CLK_HZ      = 100000000,
    parameter int FAST_HZ     = 1000,
    parameter int SLOW_HZ     = 100,
    parameter int HOLD_CYCLES = 1024,
    parameter int LOCK_BYPASS = 1
) (
    input  logic               FAB_CLK,
    input  logic               FAB_RESET,
    input  logic               FAB_LOCK,
    output logic               SYS_RESET,
    output logic               READY,
    output logic               TICK_FAST,
    output logic               TICK_SLOW,
    output logic [EPOCH_W-1:0] EPOCH,
    output logic [LOSS_W-1:0]  LOCK_LOSS_CNT
);

    localparam int N  = div_ratio(CLK_HZ, FAST_HZ);
    localparam int R  = div_ratio(FAST_HZ, SLOW_HZ);
    localparam int SW = cnt_width(HOLD_CYCLES);

    if (N < 2) begin : g_bad_fast
        $error("CLK_HZ/FAST_HZ must be an integer >= 2");
    end
    if (R < 1) begin : g_bad_slow
        $error("FAST_HZ/SLOW_HZ must be an integer >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("HOLD_CYCLES must be >= 1");
    end

    seq_state_e         state_q, state_d;
    logic [SW-1:0]      stretch_q, stretch_d;
    logic [1:0]         sync_q;
    logic               lock_s;
    logic               loss_inc;
    logic               run_d;
    logic               fast_fire, slow_fire;
    logic               sys_reset_q, ready_q;
    logic [EPOCH_W-1:0] epoch_q;
    logic [LOSS_W-1:0]  loss_q;

    always_ff @(posedge FAB_CLK) begin
        if (FAB_RESET) sync_q <= '0;
        else           sync_q <= {sync_q[0], FAB_LOCK};
    end

    // A bypassed CCC runs unlocked from RCOSC, so its lock output carries no information.
    assign lock_s = (LOCK_BYPASS != 0) ? 1'b1 : sync_q[1];

    always_comb begin
        state_d   = state_q;
        stretch_d = stretch_q;
        loss_inc  = 1'b0;
        if (FAB_RESET) begin
            state_d   = ST_RESET_HOLD;
            stretch_d = '0;
        end else begin
            case (state_q)
                ST_RESET_HOLD: begin
                    state_d   = ST_WAIT_LOCK;
                    stretch_d = '0;
                end
                ST_WAIT_LOCK: begin
                    stretch_d = '0;
                    if (lock_s) state_d = ST_STRETCH;
                end
                ST_STRETCH: begin
                    // Losing lock takes priority over completing the stretch.
                    if (!lock_s) begin
                        state_d   = ST_WAIT_LOCK;
                        stretch_d = '0;
                        loss_inc  = 1'b1;
                    end else if (stretch_q == SW'(HOLD_CYCLES - 1)) begin
                        state_d   = ST_RUN;
                        stretch_d = '0;
                    end else begin
                        stretch_d = stretch_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d  = ST_WAIT_LOCK;
                        loss_inc = 1'b1;
                    end
                end
                default: state_d = ST_RESET_HOLD;
            endcase
        end
    end

    assign run_d = (state_d == ST_RUN);

    always_ff @(posedge FAB_CLK) begin
        if (FAB_RESET) begin
            state_q     <= ST_RESET_HOLD;
            stretch_q   <= '0;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            epoch_q     <= '0;
            loss_q      <= '0;
        end else begin
            state_q     <= state_d;
            stretch_q   <= stretch_d;
            sys_reset_q <= !run_d;
            ready_q     <= run_d;
            if (loss_inc && loss_q != '1) loss_q <= loss_q + 1'b1;
            if (!run_d)         epoch_q <= '0;
            else if (slow_fire) epoch_q <= epoch_q + 1'b1;
        end
    end

    // Dividers clear on the same edge the state leaves RUN, so no tick follows a lock drop.
    tick_divider #(.DIV(N)) u_fast_div (
        .clk_i   (FAB_CLK),
        .en_i    (run_d),
        .clr_i   (!run_d),
        .fire_o  (fast_fire),
        .pulse_o (TICK_FAST)
    );

    tick_divider #(.DIV(R)) u_slow_div (
        .clk_i   (FAB_CLK),
        .en_i    (fast_fire),
        .clr_i   (!run_d),
        .fire_o  (slow_fire),
        .pulse_o (TICK_SLOW)
    );

    assign SYS_RESET     = sys_reset_q;
    assign READY         = ready_q;
    assign EPOCH         = epoch_q;
    assign LOCK_LOSS_CNT = loss_q;

endmodule
